dataflow_cond_branch: RTL and testbench
=======================================

// Module: dataflow_cond_branch
// PURPOSE
//   Registered conditional-branch router: joins a 1-bit condition token (e.g. arith_cmpi
//   result) with a WIDTH-bit data token and steers the data to the true or false output.
//   It is the consumer end of the compare path in the dataflow fabric: cmpi produces the
//   predicate, this block acts on it. Valid/ready handshake on all ports; 1-entry output buffer.
// PARAMETERS
//   WIDTH   32  data token width in bits (>=1)
//   CNT_W   16  stats counter width (used only when COND_BRANCH_STATS_EN is defined)
// PORTS
//   clk          in   1      clock; all state updates on rising edge
//   rst_n        in   1      synchronous active-low reset
//   cond_valid   in   1      condition token valid
//   cond_ready   out  1      condition token accepted when cond_valid & cond_ready
//   cond_data    in   1      1 = route to true port, 0 = route to false port
//   in_valid     in   1      data token valid
//   in_ready     out  1      data token accepted when in_valid & in_ready
//   in_data      in   WIDTH  data token
//   true_valid   out  1      true-port token valid
//   true_ready   in   1      true-port consumer ready
//   true_data    out  WIDTH  true-port token
//   false_valid  out  1      false-port token valid
//   false_ready  in   1      false-port consumer ready
//   false_data   out  WIDTH  false-port token
//   cnt_true     out  CNT_W  tokens delivered on true port (COND_BRANCH_STATS_EN only)
//   cnt_false    out  CNT_W  tokens delivered on false port (COND_BRANCH_STATS_EN only)
// BEHAVIOUR
//   - State: EMPTY, FULL_T (buffered token for true port), FULL_F (for false port).
//   - Reset (rst_n=0 at edge): state=EMPTY, buffer data=0, true_valid=false_valid=0,
//     counters=0. Reset mid-operation discards any buffered token; no output fires after.
//   - true_valid = (state==FULL_T); false_valid = (state==FULL_F); true_data and
//     false_data both drive the buffer register (only the valid port is meaningful).
//   - drain = (FULL_T & true_ready) | (FULL_F & false_ready).
//   - space = (state==EMPTY) | drain (same-cycle drain+refill gives throughput 1 token/cycle).
//   - Join: cond_ready = in_valid & space; in_ready = cond_valid & space.
//     fire = cond_valid & in_valid & space. Neither input is consumed unless both are valid.
//   - On fire: buffer <= in_data; state <= cond_data ? FULL_T : FULL_F.
//   - On drain without fire: state <= EMPTY. No drain, no fire: state/buffer hold.
//   - Latency: accepted token appears on its output valid exactly 1 cycle after fire.
//   - Output stability: while an output is valid and not ready, its data and valid hold.
//   - Ready of the non-selected port is ignored; backpressure on the selected port
//     stalls both inputs (cond_ready=in_ready=0).
//   - Upstream contract: valids held with stable data until accepted; not checked.
//   - Token order preserved; tokens never duplicated or dropped (except by reset).
// CONFIGURATION
//   COND_BRANCH_STATS_EN defined: cnt_true/cnt_false ports exist; each increments by 1 on
//     a drain of its port; saturates at 2^CNT_W-1 (no wrap); cleared by reset.
//   Not defined: cnt_* ports and counter logic absent; routing behaviour identical.
// TESTING
//   1. Reset, then cond=1/data=0xDEADBEEF both valid, true_ready=1 -> true_valid=1 next
//      cycle with true_data=0xDEADBEEF, false_valid stays 0; state back to EMPTY after.
//   2. Streams cond=1,0,1,0 with data 1..4, both outputs always ready -> one token/cycle,
//      true gets 1,3 and false gets 2,4, no bubbles after first-cycle latency.
//   3. in_valid=1, cond_valid=0 for 5 cycles -> in_ready=0, cond_ready=1 permitted but no
//      fire, outputs stay invalid; raise cond_valid -> fire that cycle.
//   4. Token buffered for false port, false_ready=0 for 4 cycles, true_ready=1 -> false_valid
//      and data stable, cond_ready=in_ready=0; false_ready=1 -> drain and refill same cycle.
//   5. rst_n=0 while FULL_T and true_ready=0 -> next cycle true_valid=0, state EMPTY,
//      counters 0; held token never observed.
//   6. COND_BRANCH_STATS_EN, CNT_W=2: deliver 5 true tokens, 1 false -> cnt_true=3
//      (saturated), cnt_false=1.

Source files
------------

// File: rtl/dataflow_cond_branch.sv
// Purpose   : conditional-branch router joining a 1-bit condition token with a data token, steering data to true/false port.
// Latency   : 1 cycle from join (fire) to output valid; throughput 1 token/cycle with same-cycle drain+refill.
// Backpress : 1-entry output buffer; a stalled selected port holds both inputs off (cond_ready=in_ready=0).
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cond_valid/ready/data        condition token (1 = true port, 0 = false port)
//   in_valid/ready/data          WIDTH-bit data token
//   true_valid/ready/data        true-port output
//   false_valid/ready/data       false-port output
//   cnt_true, cnt_false          saturating delivery counters (only with COND_BRANCH_STATS_EN)
//
// Build option: define COND_BRANCH_STATS_EN to add the CNT_W parameter, the cnt_* ports and
// the counter logic. Routing behaviour does not depend on it.

module dataflow_cond_branch #(
    parameter int WIDTH = 32
`ifdef COND_BRANCH_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cond_valid,
    output logic             cond_ready,
    input  logic             cond_data,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,

    output logic             true_valid,
    input  logic             true_ready,
    output logic [WIDTH-1:0] true_data,

    output logic             false_valid,
    input  logic             false_ready,
    output logic [WIDTH-1:0] false_data
`ifdef COND_BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_true,
    output logic [CNT_W-1:0] cnt_false
`endif
);

    // Buffer occupancy doubles as the destination tag of the held token.
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL_T = 2'd1,
        ST_FULL_F = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_buf_dat;

    logic             w_drain_t;
    logic             w_drain_f;
    logic             w_drain;
    logic             w_space;
    logic             w_fire;

    // ------------------------------------------------------------------
    // State register and data buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_buf_dat <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_buf_dat <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state, join handshake and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_drain_t   = 1'b0;
        w_drain_f   = 1'b0;
        true_valid  = 1'b0;
        false_valid = 1'b0;

        case (r_state)
            ST_FULL_T: begin
                true_valid = 1'b1;
                w_drain_t  = true_ready;
            end
            ST_FULL_F: begin
                false_valid = 1'b1;
                w_drain_f   = false_ready;
            end
            default: begin
                true_valid  = 1'b0;
                false_valid = 1'b0;
            end
        endcase

        // Only the ready of the port that owns the buffered token matters.
        w_drain = w_drain_t | w_drain_f;
        // A draining buffer can accept a new token in the same cycle.
        w_space = (r_state == ST_EMPTY) | w_drain;

        // Join: each side's ready depends on the other side's valid, so
        // neither token is consumed alone.
        cond_ready = in_valid & w_space;
        in_ready   = cond_valid & w_space;
        w_fire     = cond_valid & in_valid & w_space;

        if (w_fire) begin
            w_state_nxt = cond_data ? ST_FULL_T : ST_FULL_F;
        end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Both ports show the buffer; only the valid one carries meaning.
    assign true_data  = r_buf_dat;
    assign false_data = r_buf_dat;

`ifdef COND_BRANCH_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-port delivery counters
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt_true;
    logic [CNT_W-1:0] r_cnt_false;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_true  <= '0;
            r_cnt_false <= '0;
        end else begin
            if (w_drain_t && (r_cnt_true != '1)) begin
                r_cnt_true <= r_cnt_true + CNT_ONE;
            end
            if (w_drain_f && (r_cnt_false != '1)) begin
                r_cnt_false <= r_cnt_false + CNT_ONE;
            end
        end
    end

    assign cnt_true  = r_cnt_true;
    assign cnt_false = r_cnt_false;
`endif

endmodule

// File: tb/tb_dataflow_cond_branch.sv
// Purpose   : directed self-checking bench for dataflow_cond_branch.
// Latency   : checks 1-cycle fire-to-valid timing and back-to-back throughput.
// Backpress : exercises stalled selected port, ignored non-selected ready, reset while full.

module tb_dataflow_cond_branch;

    localparam int WIDTH = 32;
`ifdef COND_BRANCH_STATS_EN
    localparam int CNT_W = 2;
`endif

    logic             clk;
    logic             rst_n;
    logic             cond_valid;
    logic             cond_ready;
    logic             cond_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             true_valid;
    logic             true_ready;
    logic [WIDTH-1:0] true_data;
    logic             false_valid;
    logic             false_ready;
    logic [WIDTH-1:0] false_data;
`ifdef COND_BRANCH_STATS_EN
    logic [CNT_W-1:0] cnt_true;
    logic [CNT_W-1:0] cnt_false;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dataflow_cond_branch #(
        .WIDTH (WIDTH)
`ifdef COND_BRANCH_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cond_valid  (cond_valid),
        .cond_ready  (cond_ready),
        .cond_data   (cond_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .true_valid  (true_valid),
        .true_ready  (true_ready),
        .true_data   (true_data),
        .false_valid (false_valid),
        .false_ready (false_ready),
        .false_data  (false_data)
`ifdef COND_BRANCH_STATS_EN
        ,
        .cnt_true    (cnt_true),
        .cnt_false   (cnt_false)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; registered outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected data for the alternating stream.
    logic [3:0] pat;

    initial begin
        rst_n       = 1'b0;
        cond_valid  = 1'b0;
        cond_data   = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        true_ready  = 1'b0;
        false_ready = 1'b0;
        pat         = 4'b0101;   // cond for tokens 1..4 = 1,0,1,0 (bit k-1)

        step();
        step();
        // ---------------- reset state ----------------
        chk("rst_true_valid",  true_valid,  0);
        chk("rst_false_valid", false_valid, 0);
        chk("rst_true_data",   true_data,   0);
        chk("rst_false_data",  false_data,  0);
        chk("rst_cond_ready",  cond_ready,  0);
        rst_n = 1'b1;
        step();

        // ---------------- 1: single true token ----------------
        true_ready  = 1'b1;
        false_ready = 1'b1;
        cond_valid  = 1'b1;
        cond_data   = 1'b1;
        in_valid    = 1'b1;
        in_data     = 32'hDEADBEEF;
        #1;
        chk("t1_in_ready",   in_ready,   1);
        chk("t1_cond_ready", cond_ready, 1);
        step();
        cond_valid = 1'b0;
        in_valid   = 1'b0;
        chk("t1_true_valid",  true_valid,  1);
        chk("t1_true_data",   true_data,   32'hDEADBEEF);
        chk("t1_false_valid", false_valid, 0);
        step();
        chk("t1_empty_true",  true_valid,  0);
        chk("t1_empty_false", false_valid, 0);

        // ---------------- 2: alternating stream, no bubbles ----------------
        for (int k = 1; k <= 4; k++) begin
            cond_valid = 1'b1;
            in_valid   = 1'b1;
            cond_data  = pat[k-1];
            in_data    = k;
            #1;
            chk("t2_in_ready", in_ready, 1);
            step();
            if (pat[k-1]) begin
                chk("t2_true_valid",  true_valid,  1);
                chk("t2_true_data",   true_data,   k);
                chk("t2_false_valid", false_valid, 0);
            end else begin
                chk("t2_false_valid", false_valid, 1);
                chk("t2_false_data",  false_data,  k);
                chk("t2_true_valid",  true_valid,  0);
            end
        end
        cond_valid = 1'b0;
        in_valid   = 1'b0;
        step();
        chk("t2_drained_true",  true_valid,  0);
        chk("t2_drained_false", false_valid, 0);

        // ---------------- 3: data waits for condition ----------------
        in_valid  = 1'b1;
        in_data   = 32'h55;
        cond_data = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_in_ready",   in_ready,   0);
            chk("t3_cond_ready", cond_ready, 1);
            step();
            chk("t3_true_valid",  true_valid,  0);
            chk("t3_false_valid", false_valid, 0);
        end
        cond_valid = 1'b1;
        #1;
        chk("t3_fire_in_ready", in_ready, 1);
        step();
        chk("t3_false_valid_after", false_valid, 1);
        chk("t3_false_data_after",  false_data,  32'h55);

        // ---------------- 4: false port stalled ----------------
        false_ready = 1'b0;
        true_ready  = 1'b1;
        cond_data   = 1'b1;
        in_data     = 32'hA5;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t4_cond_ready", cond_ready, 0);
            chk("t4_in_ready",   in_ready,   0);
            step();
            chk("t4_false_valid", false_valid, 1);
            chk("t4_false_data",  false_data,  32'h55);
            chk("t4_true_valid",  true_valid,  0);
        end
        false_ready = 1'b1;
        #1;
        chk("t4_refill_in_ready",   in_ready,   1);
        chk("t4_refill_cond_ready", cond_ready, 1);
        step();
        cond_valid = 1'b0;
        in_valid   = 1'b0;
        chk("t4_true_valid",  true_valid,  1);
        chk("t4_true_data",   true_data,   32'hA5);
        chk("t4_false_gone",  false_valid, 0);

        // ---------------- 5: reset while FULL_T and stalled ----------------
        true_ready = 1'b0;
        step();
        chk("t5_held_true_valid", true_valid, 1);
        rst_n = 1'b0;
        step();
        chk("t5_rst_true_valid",  true_valid,  0);
        chk("t5_rst_false_valid", false_valid, 0);
        chk("t5_rst_data",        true_data,   0);
`ifdef COND_BRANCH_STATS_EN
        chk("t5_rst_cnt_true",  cnt_true,  0);
        chk("t5_rst_cnt_false", cnt_false, 0);
`endif
        rst_n      = 1'b1;
        true_ready = 1'b1;
        step();
        chk("t5_after_true_valid",  true_valid,  0);
        step();
        chk("t5_after2_true_valid", true_valid,  0);

`ifdef COND_BRANCH_STATS_EN
        // ---------------- 6: saturating counters ----------------
        false_ready = 1'b1;
        true_ready  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cond_valid = 1'b1;
            in_valid   = 1'b1;
            cond_data  = (k < 5);
            in_data    = 32'h100 + k;
            step();
        end
        cond_valid = 1'b0;
        in_valid   = 1'b0;
        step();
        chk("t6_cnt_true_sat", cnt_true,  3);
        chk("t6_cnt_false",    cnt_false, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
